// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Playfield geometry shared by the raccoon controller, the obstacle
//   controller and the sprite renderer. The start row lives here so that the
//   block that moves the raccoon and the block that clears the collision flag
//   always agree on where "home" is.
//
//   Contents:
//     GAME_WIDTH / GAME_HEIGHT     playfield size in pixels
//     GRID_WIDTH / GRID_HEIGHT     cell size in pixels
//     PLAYER_WIDTH / PLAYER_HEIGHT raccoon sprite size in pixels
//     RACCOON_SPEED                pixels per raccoon move (one grid cell)
//     START_ROW_Y                  Y of the bottom (start) row, grid aligned
//     coll_state_t                 collision FSM state encoding
//     clamp_level()                maps any 4-bit level onto 1..9
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int GAME_WIDTH    = 640;
   localparam int GAME_HEIGHT   = 480;
   localparam int GRID_WIDTH    = 32;
   localparam int GRID_HEIGHT   = 32;
   localparam int PLAYER_WIDTH  = 32;
   localparam int PLAYER_HEIGHT = 32;
   localparam int RACCOON_SPEED = GRID_HEIGHT;

   // Lowest grid-aligned row the raccoon sprite fits in entirely.
   localparam int START_ROW_Y = (GAME_HEIGHT - PLAYER_HEIGHT) / GRID_HEIGHT * GRID_HEIGHT;

   typedef enum logic {
      COLL_CLEAR = 1'b0,
      COLL_HIT   = 1'b1
   } coll_state_t;

   // Level 0 is treated as the first level, anything above 9 as the last.
   function automatic logic [3:0] clamp_level(input logic [3:0] level);
      if (level == 4'd0) return 4'd1;
      if (level > 4'd9)  return 4'd9;
      return level;
   endfunction

endpackage

// File: rtl/obstacle_lane.sv
// -----------------------------------------------------------------------------
// obstacle_lane
//   One car lane: a step-period counter, the car X register with wrap-around
//   stepping in a fixed direction, and the combinational raccoon/car overlap
//   test for this lane's row.
//
//   Ports:
//     i_Clk        system clock
//     i_Rst        asynchronous reset, active-high
//     tick         one-cycle movement strobe from the shared prescaler
//     base_period  level-dependent step period before the per-lane offset
//     raccoon_x    raccoon X in pixels
//     raccoon_y    raccoon Y in pixels
//     car_x        car X in pixels, always 0..GAME_WIDTH-1
//     hit          raccoon overlaps this lane's car (combinational)
// -----------------------------------------------------------------------------
module obstacle_lane
   import game_pkg::*;
#(
   parameter int LANE_IDX   = 0,
   parameter bit MOVE_RIGHT = 1'b1,
   parameter int INIT_X     = 0,
   parameter int LANE_ROW0  = 3,
   parameter int CAR_WIDTH  = 64,
   parameter int STEP_PX    = 8
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       tick,
   input  logic [7:0] base_period,
   input  logic [9:0] raccoon_x,
   input  logic [9:0] raccoon_y,
   output logic [9:0] car_x,
   output logic       hit
);

   localparam logic [7:0]  LANE_OFS = 8'(LANE_IDX);
   localparam logic [10:0] GW       = 11'(GAME_WIDTH);
   localparam logic [10:0] STEP     = 11'(STEP_PX);
   localparam logic [10:0] CW       = 11'(CAR_WIDTH);
   localparam logic [10:0] PW       = 11'(PLAYER_WIDTH);
   localparam logic [9:0]  ROW_Y    = 10'((LANE_ROW0 + LANE_IDX) * GRID_HEIGHT);
   localparam logic [9:0]  X_RST    = 10'(INIT_X);

   logic [7:0]  period;
   logic [7:0]  cnt;
   logic        step_due;
   logic [10:0] x_ext;
   logic [10:0] x_step;
   logic [10:0] rx_ext;
   logic [10:0] car_end;

   // Higher lanes run slightly slower so the cars drift out of phase.
   assign period   = base_period + LANE_OFS;
   // ">=" rather than "==": if the level drops the period below the current
   // count, the next tick still steps once instead of waiting for a wrap.
   assign step_due = cnt >= (period - 8'd1);
   assign x_ext    = {1'b0, car_x};

   always_comb begin
      // NOTE: x_step gets a value before any branch so no path leaves it
      // unassigned; a missing default here would infer a latch.
      x_step = x_ext;
      if (MOVE_RIGHT) begin
         x_step = x_ext + STEP;
         if (x_step >= GW) x_step = x_step - GW;
      end else if (x_ext < STEP) begin
         x_step = x_ext + GW - STEP;
      end else begin
         x_step = x_ext - STEP;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         cnt   <= '0;
         car_x <= X_RST;
      end else if (tick) begin
         if (step_due) begin
            cnt   <= '0;
            car_x <= x_step[9:0];
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Span overlap in 11 bits; the second term covers a car that has wrapped
   // past the right edge and reappears at X = 0.
   assign rx_ext  = {1'b0, raccoon_x};
   assign car_end = x_ext + CW;
   assign hit     = (raccoon_y == ROW_Y) &&
                    (((rx_ext + PW > x_ext) && (rx_ext < car_end)) ||
                     ((car_end > GW) && (rx_ext < car_end - GW)));

endmodule

// File: rtl/obstacle_ctrl.sv
// -----------------------------------------------------------------------------
// obstacle_ctrl
//   Car traffic and collision detection. A shared prescaler produces a
//   movement tick; each lane steps its car after a level-dependent number of
//   ticks. Any lane overlap raises a sticky collision flag that only drops
//   once the raccoon is back on the start row, because the raccoon
//   controller samples it on a slow divided clock.
//
//   Optional build macro: OBSTACLE_FREEZE_EN adds i_Freeze, which halts the
//   prescaler and lane counters and masks new hits while high.
//
//   Ports:
//     i_Clk        system clock
//     i_Rst        asynchronous reset, active-high
//     i_Raccoon_X  raccoon X in pixels
//     i_Raccoon_Y  raccoon Y in pixels
//     i_Level      current level, clamped to 1..9
//     i_Freeze     (OBSTACLE_FREEZE_EN only) hold traffic, mask new hits
//     o_Car_X      packed car X; lane k at bits [10k+9:10k]
//     o_Collision  sticky collision flag
// -----------------------------------------------------------------------------
module obstacle_ctrl
   import game_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int LANE_ROW0   = 3,
   parameter int CAR_WIDTH   = 64,
   parameter int TICK_DIV    = 25000,
   parameter int BASE_PERIOD = 40,
   parameter int LEVEL_DEC   = 4,
   parameter int MIN_PERIOD  = 4,
   parameter int STEP_PX     = 8
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic [9:0]              i_Raccoon_X,
   input  logic [9:0]              i_Raccoon_Y,
   input  logic [3:0]              i_Level,
`ifdef OBSTACLE_FREEZE_EN
   input  logic                    i_Freeze,
`endif
   output logic [10*NUM_LANES-1:0] o_Car_X,
   output logic                    o_Collision
);

   localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [7:0]         BASE_P    = 8'(BASE_PERIOD);
   localparam logic [7:0]         MIN_P     = 8'(MIN_PERIOD);
   localparam logic [7:0]         DEC_P     = 8'(LEVEL_DEC);
   localparam logic [9:0]         START_Y   = 10'(START_ROW_Y);

   logic                 freeze;
   logic [PRESC_W-1:0]   presc;
   logic                 tick;
   logic [3:0]           lvl;
   logic [7:0]           lvl_off;
   logic [7:0]           base_period;
   logic [NUM_LANES-1:0] lane_hit;
   logic                 any_hit;
   coll_state_t          state;

`ifdef OBSTACLE_FREEZE_EN
   assign freeze = i_Freeze;
`else
   assign freeze = 1'b0;
`endif

   // ---------------------------------------------------------------- prescaler
   assign tick = !freeze && (presc == PRESC_MAX);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         presc <= '0;
      end else if (!freeze) begin
         presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end
   end

   // ------------------------------------------------------------ step period
   // The floor is tested before subtracting so the 8-bit result never wraps.
   always_comb begin
      lvl         = clamp_level(i_Level);
      lvl_off     = {4'd0, lvl - 4'd1} * DEC_P;
      base_period = (lvl_off >= BASE_P - MIN_P) ? MIN_P : BASE_P - lvl_off;
   end

   // ------------------------------------------------------------------ lanes
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      obstacle_lane #(
         .LANE_IDX   (k),
         .MOVE_RIGHT ((k % 2) == 0),
         .INIT_X     ((k * (GAME_WIDTH / NUM_LANES)) / GRID_WIDTH * GRID_WIDTH),
         .LANE_ROW0  (LANE_ROW0),
         .CAR_WIDTH  (CAR_WIDTH),
         .STEP_PX    (STEP_PX)
      ) u_lane (
         .i_Clk       (i_Clk),
         .i_Rst       (i_Rst),
         .tick        (tick),
         .base_period (base_period),
         .raccoon_x   (i_Raccoon_X),
         .raccoon_y   (i_Raccoon_Y),
         .car_x       (o_Car_X[10*k +: 10]),
         .hit         (lane_hit[k])
      );
   end

   // ---------------------------------------------------------- collision FSM
   assign any_hit = (|lane_hit) && !freeze;

   // Leaving HIT is checked before any new hit, so reaching the start row
   // always wins; a fresh hit can only re-arm on a later cycle from CLEAR.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= COLL_CLEAR;
         o_Collision <= 1'b0;
      end else begin
         case (state)
            COLL_CLEAR: begin
               if (any_hit) begin
                  state       <= COLL_HIT;
                  o_Collision <= 1'b1;
               end
            end
            COLL_HIT: begin
               if (i_Raccoon_Y == START_Y) begin
                  state       <= COLL_CLEAR;
                  o_Collision <= 1'b0;
               end
            end
            default: begin
               state       <= COLL_CLEAR;
               o_Collision <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obstacle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_obstacle_ctrl
//   Scoreboard bench for obstacle_ctrl with a short prescaler (TICK_DIV = 4),
//   so one movement tick is 4 clocks and a level-9 lane-0 step is 32 clocks.
//   The stimulus thread pushes expected values tagged with the clock edge
//   (counted from reset release) after which they must hold; the monitor
//   compares them on the following falling edge.
// -----------------------------------------------------------------------------
module tb_obstacle_ctrl;

   localparam int TICK_DIV  = 4;
   localparam int NUM_LANES = 4;
   localparam int SEL_COLL  = NUM_LANES;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b0;
   logic [9:0]  raccoon_x = '0;
   logic [9:0]  raccoon_y = '0;
   logic [3:0]  level = 4'd9;
`ifdef OBSTACLE_FREEZE_EN
   logic        freeze = 1'b0;
`endif
   logic [39:0] car_x;
   logic        collision;

   obstacle_ctrl #(
      .NUM_LANES (NUM_LANES),
      .TICK_DIV  (TICK_DIV)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_Raccoon_X (raccoon_x),
      .i_Raccoon_Y (raccoon_y),
      .i_Level     (level),
`ifdef OBSTACLE_FREEZE_EN
      .i_Freeze    (freeze),
`endif
      .o_Car_X     (car_x),
      .o_Collision (collision)
   );

   always #5 i_Clk = ~i_Clk;

   int cyc = 0;
   always @(posedge i_Clk) cyc <= cyc + 1;

   typedef struct {
      int    due;
      int    sel;
      int    val;
      string name;
   } exp_t;

   exp_t  sb[$];
   int    base = 0;
   int    n_checks = 0;
   int    n_errors = 0;
   int    mon_i;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // e is an edge index relative to the last reset release.
   task automatic expect_at(input int e, input int sel, input int val);
      exp_t t;
      t.due = base + e;
      t.sel = sel;
      t.val = val;
      t.name = (sel == SEL_COLL) ? $sformatf("collision@%0d", e)
                                 : $sformatf("lane%0d_x@%0d", sel, e);
      sb.push_back(t);
   endtask

   task automatic expect_lanes(input int e, input int x0, input int x1,
                               input int x2, input int x3);
      expect_at(e, 0, x0);
      expect_at(e, 1, x1);
      expect_at(e, 2, x2);
      expect_at(e, 3, x3);
   endtask

   // Wait until edge e (relative) has passed, then sit 1 time unit after it.
   task automatic goto(input int e);
      while (cyc < base + e) begin
         @(posedge i_Clk);
         #1;
      end
   endtask

   task automatic release_reset();
      @(posedge i_Clk);
      #1;
      i_Rst = 1'b0;
      base  = cyc;
   endtask

   task automatic enter_reset();
      @(posedge i_Clk);
      #1;
      i_Rst = 1'b1;
      repeat (3) @(posedge i_Clk);
      #1;
   endtask

   // Closed-form position of lane k after e edges at a constant period.
   function automatic int model_x(input int k, input int per, input int e);
      int s;
      int x0;
      s  = e / (TICK_DIV * per);
      x0 = k * 160;
      if ((k % 2) == 0) return (x0 + 8 * s) % 640;
      return (x0 + 640 * 1000 - 8 * s) % 640;
   endfunction

   // ------------------------------------------------------------- monitor
   always @(negedge i_Clk) begin
      mon_i = 0;
      while (mon_i < sb.size()) begin
         if (sb[mon_i].due <= cyc) begin
            if (sb[mon_i].sel == SEL_COLL)
               check(sb[mon_i].name, int'(collision), sb[mon_i].val);
            else
               check(sb[mon_i].name, int'(car_x[10*sb[mon_i].sel +: 10]), sb[mon_i].val);
            sb.delete(mon_i);
         end else begin
            mon_i++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      #2 i_Rst = 1'b1;
      repeat (3) @(posedge i_Clk);
      #1;

      // Reset state.
      base = cyc;
      expect_lanes(1, 0, 160, 320, 480);
      expect_at(1, SEL_COLL, 0);
      repeat (2) @(posedge i_Clk);
      #1;

      // ---- Level 9: periods 8/9/10/11 ticks.
      level = 4'd9;
      release_reset();
      expect_at(31, 0, 0);    expect_at(32, 0, 8);    expect_at(64, 0, 16);
      expect_at(35, 1, 160);  expect_at(36, 1, 152);
      expect_at(39, 2, 320);  expect_at(40, 2, 328);
      expect_at(43, 3, 480);  expect_at(44, 3, 472);
      // Left wrap of lane 1: 0 -> 632.
      expect_at(755, 1, 0);   expect_at(756, 1, 632); expect_at(792, 1, 624);
      // Car at 280, raccoon at X=300 on lane 0's row.
      expect_at(1124, 0, 280);
      expect_at(1124, SEL_COLL, 0); expect_at(1125, SEL_COLL, 1);
      expect_at(1140, SEL_COLL, 1); expect_at(1150, SEL_COLL, 1);
      expect_at(1151, SEL_COLL, 0);
      // Car at 288: raccoon just touching on the left, then overlapping.
      expect_at(1156, SEL_COLL, 0); expect_at(1160, SEL_COLL, 0);
      expect_at(1163, SEL_COLL, 1); expect_at(1167, SEL_COLL, 0);
      // Car at 296: raccoon just past the right end, then overlapping.
      expect_at(1187, SEL_COLL, 0); expect_at(1190, SEL_COLL, 0);
      expect_at(1193, SEL_COLL, 1); expect_at(1197, SEL_COLL, 0);
      // Car at 600 covers 600..639 and 0..23.
      expect_at(2401, 0, 600);
      expect_at(2403, SEL_COLL, 1); expect_at(2407, SEL_COLL, 0);
      expect_at(2411, SEL_COLL, 0); expect_at(2416, SEL_COLL, 0);
      // Right wrap of lane 0: 632 -> 0.
      expect_at(2559, 0, 632); expect_at(2560, 0, 0);
      // Collision raised, then reset asserted mid-cycle.
      expect_at(2601, SEL_COLL, 1);
      expect_at(2609, 0, model_x(0, 8, 2609));
      expect_at(2609, 1, model_x(1, 9, 2609));
      expect_lanes(2610, 0, 160, 320, 480);
      expect_at(2610, SEL_COLL, 0);

      goto(1124); raccoon_y = 10'd96;  raccoon_x = 10'd300;
      goto(1150); raccoon_y = 10'd448;
      goto(1155); raccoon_y = 10'd96;  raccoon_x = 10'd256;
      goto(1162); raccoon_x = 10'd257;
      goto(1166); raccoon_y = 10'd448;
      goto(1186); raccoon_y = 10'd96;  raccoon_x = 10'd360;
      goto(1192); raccoon_x = 10'd359;
      goto(1196); raccoon_y = 10'd448;
      goto(2402); raccoon_y = 10'd96;  raccoon_x = 10'd0;
      goto(2406); raccoon_y = 10'd448;
      goto(2410); raccoon_y = 10'd96;  raccoon_x = 10'd24;
      goto(2418); raccoon_y = 10'd448;
      goto(2600); raccoon_y = 10'd96;  raccoon_x = 10'd0;
      goto(2610); i_Rst = 1'b1;
      raccoon_y = 10'd0;
      raccoon_x = 10'd0;
      repeat (3) @(posedge i_Clk);
      #1;

      // ---- Level 15 clamps to 9.
      level = 4'd15;
      release_reset();
      expect_at(31, 0, 0); expect_at(32, 0, 8);
      expect_at(43, 3, 480); expect_at(44, 3, 472);
      goto(50);
      enter_reset();

      // ---- Level 0 clamps to 1 (periods 40/41/42/43), then a level change.
      level = 4'd0;
      release_reset();
      expect_at(159, 0, 0);   expect_at(160, 0, 8);
      expect_at(163, 1, 160); expect_at(164, 1, 152);
      expect_at(171, 3, 480); expect_at(172, 3, 472);
      // Lane 0 count is 20 when level 9 arrives: the next tick steps once.
      expect_at(243, 0, 8);   expect_at(244, 0, 16);
      expect_at(275, 0, 16);  expect_at(276, 0, 24);
      goto(241); level = 4'd9;
      goto(280);
      enter_reset();

`ifdef OBSTACLE_FREEZE_EN
      // ---- Freeze: no motion and no new hit while high.
      level     = 4'd9;
      freeze    = 1'b1;
      raccoon_y = 10'd96;
      raccoon_x = 10'd0;
      release_reset();
      expect_at(40, 0, 0);  expect_at(40, SEL_COLL, 0);
      expect_at(99, 0, 0);  expect_at(99, SEL_COLL, 0);
      expect_at(100, SEL_COLL, 1);
      expect_at(130, 0, 0); expect_at(131, 0, 8);
      expect_at(136, SEL_COLL, 0);
      expect_at(200, 0, 8);
      goto(99);  freeze = 1'b0;
      goto(135); freeze = 1'b1; raccoon_y = 10'd448;
      goto(200);
      freeze = 1'b0;
`endif

      // Drain anything still pending, with a bound.
      for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge i_Clk);
      #1;
      while (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: never compared, expected %0d", sb[0].name, sb[0].val);
         sb.delete(0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/obstacle_ctrl.md
Name: obstacle_ctrl

Overview:
- Produces the obstacle (car) traffic and the collision flag consumed by the raccoon controller.
- Closes the loop: takes raccoon X/Y and level from the raccoon controller, moves NUM_LANES cars horizontally with wrap-around at a level-dependent speed, and raises a sticky collision until the raccoon is back on the start row.
- Sits between the raccoon controller and the VGA sprite renderer.

Parameters:
- GAME_WIDTH, 640, playfield width in pixels
- GAME_HEIGHT, 480, playfield height in pixels
- GRID_WIDTH, 32, horizontal cell size in pixels
- GRID_HEIGHT, 32, vertical cell size in pixels
- PLAYER_WIDTH, 32, raccoon sprite width
- CAR_WIDTH, 64, car sprite width
- NUM_LANES, 4, number of car lanes, one car per lane
- LANE_ROW0, 3, grid row of lane 0; lane k is at row LANE_ROW0+k
- TICK_DIV, 25000, i_Clk cycles per movement tick (1 kHz at 25 MHz)
- BASE_PERIOD, 40, ticks between steps at level 1
- LEVEL_DEC, 4, period reduction per level above 1
- MIN_PERIOD, 4, floor on the step period
- STEP_PX, 8, pixels moved per step

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous reset, active-high
- i_Raccoon_X  in  10  raccoon X in pixels
- i_Raccoon_Y  in  10  raccoon Y in pixels
- i_Level  in  4  current level, 1..9
- o_Car_X  out  10*NUM_LANES  packed car X positions; lane k at bits [10k+9:10k]
- o_Collision  out  1  sticky collision flag to the raccoon controller

Behaviour:
- Reset (async, i_Rst high):
  - lane k car X = k*(GAME_WIDTH/NUM_LANES), rounded down to a GRID_WIDTH multiple
  - o_Collision = 0
  - prescaler = 0; all lane counters = 0
  - Reset mid-operation aborts any step and collision immediately.
- Prescaler: counts 0..TICK_DIV-1. The tick strobe is high for one cycle on the wrap.
- Level clamp: lvl = 1 if i_Level == 0; lvl = 9 if i_Level > 9; otherwise lvl = i_Level.
- Period: P = max(MIN_PERIOD, BASE_PERIOD - (lvl-1)*LEVEL_DEC) + k. Computed in 8 bits unsigned, with no underflow (the max is applied before the subtract wraps).
- Lane counter k:
  - increments on each tick
  - when the counter >= P-1 on a tick, it clears and lane k takes one step
  - a level change takes effect on the following tick compare and never causes a lost or double step
- Direction: even lanes move right, odd lanes move left.
- Right step: X' = X+STEP_PX; if X' >= GAME_WIDTH then X' -= GAME_WIDTH.
- Left step: if X < STEP_PX then X' = X+GAME_WIDTH-STEP_PX; otherwise X' = X-STEP_PX.
- Width rule: compute X' in 11 bits and truncate to 10 bits; X stays in 0..GAME_WIDTH-1 at all times.
- Hit_k (combinational):
  - condition 1: i_Raccoon_Y == (LANE_ROW0+k)*GRID_HEIGHT
  - condition 2 (span overlap, 11-bit compare): (RX+PLAYER_WIDTH > X and RX < X+CAR_WIDTH), or (X+CAR_WIDTH > GAME_WIDTH and RX < X+CAR_WIDTH-GAME_WIDTH)
  - hit = condition 1 and condition 2
- Collision FSM (2 states):
  - CLEAR: o_Collision = 0. Go to HIT on the cycle after any Hit_k is 1, giving 1-cycle registered latency.
  - HIT: o_Collision = 1. Go back to CLEAR when i_Raccoon_Y == start row, where start row = (GAME_HEIGHT-PLAYER_HEIGHT)/GRID_HEIGHT*GRID_HEIGHT with PLAYER_HEIGHT = 32.
  - The flag is sticky because the raccoon controller samples it on a slow divided clock.
- Simultaneous Hit_k and start-row in HIT: start-row wins → CLEAR. Re-entry to HIT occurs only when a hit is present on a later cycle.
- Simultaneous hit in several lanes → single HIT. Car motion continues in every state.

Optional Feature:
- Macro OBSTACLE_FREEZE_EN.
- When defined, adds port i_Freeze (in, 1):
  - while i_Freeze is high, the prescaler and all lane counters hold, cars do not move, and Hit_k is masked (CLEAR cannot enter HIT)
  - a HIT already present still clears normally at the start row
- When not defined, there is no port and cars always move.

Decomposition:
- Package game_pkg holds GAME_WIDTH, GAME_HEIGHT, GRID_WIDTH, GRID_HEIGHT, PLAYER_WIDTH, PLAYER_HEIGHT, RACCOON_SPEED and the start-row constant. The raccoon controller and this block must agree on the start row, so it lives in one place.
- One sub-module, obstacle_lane:
  - instantiated NUM_LANES times through a generate loop
  - parameters: lane index, direction, initial X
  - holds the period counter, the X register and step/wrap logic, and produces Hit_k
- The top level holds the prescaler, the level clamp and the collision FSM.

Test Plan:
- Reset → o_Car_X lanes = 0/160/320/480 and o_Collision = 0. Assert i_Rst mid-run → same values asynchronously.
- Level 1, lane 0 → steps every 40 ticks (1,000,000 cycles). Level 9 → period 8 → X increments by 8 every 8 ticks.
- Right wrap: lane 0 X = 632 + step → 0. Left wrap: lane 1 X = 4 → 636.
- Raccoon Y = 96, X = 300, lane 0 car X = 280 → o_Collision = 1 one cycle later. Hold Y = 96 → stays 1. Y = 448 → 0 next cycle.
- Wrapped overlap: lane 0 X = 600 (covers 600..639 and 0..23), raccoon X = 0, Y = 96 → collision. Raccoon X = 32 → no collision.
- i_Level = 0 → behaves as level 1. i_Level = 15 → behaves as level 9. With OBSTACLE_FREEZE_EN: i_Freeze = 1 → X frozen for 10^6 cycles and no collision on overlap.
